// File: rtl/issue_queue_param.sv
// issue_queue_param: out-of-order issue queue with multi-lane dispatch, CDB wakeup and oldest-first select
module issue_queue_param #(
    parameter int         DEPTH  = 16,
    parameter int         DISP_W = 3,
    parameter int         CDB_N  = 5,
    parameter int         PREG_W = 6,
    parameter int         ROB_W  = 6,
    parameter int         IMM_W  = 32,
    parameter logic [2:0] Q_TYPE = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      stall_in_i,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    input  logic [DISP_W-1:0]         disp_valid_i,
    input  logic [DISP_W*3-1:0]       disp_type_i,
    input  logic [DISP_W*PREG_W-1:0]  disp_pj_i,
    input  logic [DISP_W*PREG_W-1:0]  disp_pk_i,
    input  logic [DISP_W-1:0]         disp_rdy_j_i,
    input  logic [DISP_W-1:0]         disp_rdy_k_i,
    input  logic [DISP_W*IMM_W-1:0]   disp_imm_i,
    input  logic [DISP_W*ROB_W-1:0]   disp_rob_i,
    input  logic [ROB_W-1:0]          ptr_old_i,
    input  logic [CDB_N-1:0]          cdb_valid_i,
    input  logic [CDB_N-1:0]          cdb_regwr_i,
    input  logic [CDB_N*PREG_W-1:0]   cdb_pd_i,
    output logic                      iss_valid_o,
    input  logic                      iss_ready_i,
    output logic [PREG_W-1:0]         iss_pj_o,
    output logic [PREG_W-1:0]         iss_pk_o,
    output logic [IMM_W-1:0]          iss_imm_o,
    output logic [ROB_W-1:0]          iss_rob_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]  vld_q, vld_d, rj_q, rj_d, rk_q, rk_d, taken;
    logic [PREG_W-1:0] pj_q [DEPTH];
    logic [PREG_W-1:0] pj_d [DEPTH];
    logic [PREG_W-1:0] pk_q [DEPTH];
    logic [PREG_W-1:0] pk_d [DEPTH];
    logic [IMM_W-1:0]  imm_q [DEPTH];
    logic [IMM_W-1:0]  imm_d [DEPTH];
    logic [ROB_W-1:0]  rob_q [DEPTH];
    logic [ROB_W-1:0]  rob_d [DEPTH];
    logic [ROB_W-1:0]  age, best;
    logic [IW-1:0]     sel;
    logic [CW-1:0]     cnt;
    logic              found, adv, do_disp, placed;
    logic              iss_valid_q;
    logic [PREG_W-1:0] iss_pj_q, iss_pk_q;
    logic [IMM_W-1:0]  iss_imm_q;
    logic [ROB_W-1:0]  iss_rob_q;

    function automatic logic wake(input logic [PREG_W-1:0] tag);
        logic w;
        w = 1'b0;
        for (int c = 0; c < CDB_N; c++)
            w |= cdb_valid_i[c] && cdb_regwr_i[c] && (cdb_pd_i[c*PREG_W +: PREG_W] == tag);
        return w;
    endfunction

    // occupancy count and full flag from registered state only
    always_comb begin
        cnt = '0;
        for (int e = 0; e < DEPTH; e++) cnt += CW'(vld_q[e]);
        count_o = cnt;
        full_o  = (CW'(DEPTH) - cnt) < CW'(DISP_W);
    end

    // oldest-ready select, wakeup, issue free and in-order lane allocation
    always_comb begin
        vld_d   = vld_q;
        rj_d    = rj_q;
        rk_d    = rk_q;
        pj_d    = pj_q;
        pk_d    = pk_q;
        imm_d   = imm_q;
        rob_d   = rob_q;
        found   = 1'b0;
        sel     = '0;
        best    = '0;
        age     = '0;
        placed  = 1'b0;
        adv     = !iss_valid_q || iss_ready_i;
        do_disp = !full_o && !stall_in_i && !flush_i;
        for (int e = 0; e < DEPTH; e++) begin
            age = rob_q[e] - ptr_old_i;
            if (vld_q[e] && rj_q[e] && rk_q[e] && (!found || age < best)) begin
                found = 1'b1;
                sel   = IW'(e);
                best  = age;
            end
            rj_d[e] = rj_q[e] | wake(pj_q[e]);
            rk_d[e] = rk_q[e] | wake(pk_q[e]);
        end
        if (adv && found) vld_d[sel] = 1'b0;
        taken = vld_q;
        for (int l = 0; l < DISP_W; l++) begin
            placed = 1'b0;
            if (do_disp && disp_valid_i[l] && disp_type_i[l*3 +: 3] == Q_TYPE) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (!placed && !taken[e]) begin
                        placed   = 1'b1;
                        taken[e] = 1'b1;
                        vld_d[e] = 1'b1;
                        pj_d[e]  = disp_pj_i[l*PREG_W +: PREG_W];
                        pk_d[e]  = disp_pk_i[l*PREG_W +: PREG_W];
                        rj_d[e]  = disp_rdy_j_i[l] | wake(disp_pj_i[l*PREG_W +: PREG_W]);
                        rk_d[e]  = disp_rdy_k_i[l] | wake(disp_pk_i[l*PREG_W +: PREG_W]);
                        imm_d[e] = disp_imm_i[l*IMM_W +: IMM_W];
                        rob_d[e] = disp_rob_i[l*ROB_W +: ROB_W];
                    end
                end
            end
        end
    end

    // entry storage; flush frees every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            rj_q  <= '0;
            rk_q  <= '0;
            pj_q  <= '{default: '0};
            pk_q  <= '{default: '0};
            imm_q <= '{default: '0};
            rob_q <= '{default: '0};
        end else if (flush_i) begin
            vld_q <= '0;
            rj_q  <= '0;
            rk_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rj_q  <= rj_d;
            rk_q  <= rk_d;
            pj_q  <= pj_d;
            pk_q  <= pk_d;
            imm_q <= imm_d;
            rob_q <= rob_d;
        end
    end

    // issue register; fields forced to zero whenever it is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush_i) begin
            iss_valid_q <= 1'b0;
            iss_pj_q    <= '0;
            iss_pk_q    <= '0;
            iss_imm_q   <= '0;
            iss_rob_q   <= '0;
        end else if (adv) begin
            iss_valid_q <= found;
            iss_pj_q    <= found ? pj_q[sel] : '0;
            iss_pk_q    <= found ? pk_q[sel] : '0;
            iss_imm_q   <= found ? imm_q[sel] : '0;
            iss_rob_q   <= found ? rob_q[sel] : '0;
        end
    end

    assign iss_valid_o = iss_valid_q;
    assign iss_pj_o    = iss_pj_q;
    assign iss_pk_o    = iss_pk_q;
    assign iss_imm_o   = iss_imm_q;
    assign iss_rob_o   = iss_rob_q;
endmodule

// File: tb/tb_issue_queue_param.sv
// tb_issue_queue_param: directed scoreboard bench for the issue queue at default parameters
module tb_issue_queue_param;
    typedef struct {
        logic [5:0]  pj;
        logic [5:0]  pk;
        logic [31:0] imm;
        logic [5:0]  rob;
    } uop_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, stall_in = 1'b0, iss_ready = 1'b1;
    logic        full, iss_valid;
    logic [4:0]  count;
    logic [2:0]  disp_valid = '0, disp_rdy_j = '0, disp_rdy_k = '0;
    logic [8:0]  disp_type = '0;
    logic [17:0] disp_pj = '0, disp_pk = '0, disp_rob = '0;
    logic [95:0] disp_imm = '0;
    logic [5:0]  ptr_old = '0;
    logic [4:0]  cdb_valid = '0, cdb_regwr = '0;
    logic [29:0] cdb_pd = '0;
    logic [5:0]  iss_pj, iss_pk, iss_rob;
    logic [31:0] iss_imm;
    uop_t        sb[$];
    int          checks = 0, errors = 0;

    issue_queue_param dut (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_in_i(stall_in),
        .full_o(full), .count_o(count),
        .disp_valid_i(disp_valid), .disp_type_i(disp_type),
        .disp_pj_i(disp_pj), .disp_pk_i(disp_pk),
        .disp_rdy_j_i(disp_rdy_j), .disp_rdy_k_i(disp_rdy_k),
        .disp_imm_i(disp_imm), .disp_rob_i(disp_rob), .ptr_old_i(ptr_old),
        .cdb_valid_i(cdb_valid), .cdb_regwr_i(cdb_regwr), .cdb_pd_i(cdb_pd),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
        .iss_pj_o(iss_pj), .iss_pk_o(iss_pk), .iss_imm_o(iss_imm), .iss_rob_o(iss_rob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int l, input logic [5:0] pj, input logic rj,
                        input logic [5:0] pk, input logic rk, input logic [5:0] rob);
        disp_valid[l]        = 1'b1;
        disp_type[l*3 +: 3]  = 3'd0;
        disp_pj[l*6 +: 6]    = pj;
        disp_pk[l*6 +: 6]    = pk;
        disp_rdy_j[l]        = rj;
        disp_rdy_k[l]        = rk;
        disp_imm[l*32 +: 32] = 32'h1000 + 32'(rob);
        disp_rob[l*6 +: 6]   = rob;
    endtask

    task automatic exp_iss(input logic [5:0] pj, input logic [5:0] pk, input logic [5:0] rob);
        uop_t u;
        u.pj  = pj;
        u.pk  = pk;
        u.imm = 32'h1000 + 32'(rob);
        u.rob = rob;
        sb.push_back(u);
    endtask

    task automatic cdb(input int c, input logic rw, input logic [5:0] pd);
        cdb_valid[c]       = 1'b1;
        cdb_regwr[c]       = rw;
        cdb_pd[c*6 +: 6]   = pd;
    endtask

    task automatic clr();
        disp_valid = '0;
        disp_type  = '0;
        disp_rdy_j = '0;
        disp_rdy_k = '0;
        cdb_valid  = '0;
        cdb_regwr  = '0;
        cdb_pd     = '0;
    endtask

    // one clock; a uop newly loaded into the issue register is popped from the scoreboard
    task automatic step();
        logic adv;
        uop_t u;
        adv = !iss_valid || iss_ready;
        @(posedge clk);
        #1;
        if (adv && iss_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_issue observed rob=%0d expected none", iss_rob);
            end
            if (sb.size() != 0) begin
                u = sb.pop_front();
                chk("iss_rob", 64'(iss_rob), 64'(u.rob));
                chk("iss_pj", 64'(iss_pj), 64'(u.pj));
                chk("iss_pk", 64'(iss_pk), 64'(u.pk));
                chk("iss_imm", 64'(iss_imm), 64'(u.imm));
            end
        end
        if (!iss_valid) chk("iss_zero", 64'({iss_pj, iss_pk, iss_imm, iss_rob}), 64'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        rst = 1'b1;

        // basic ready dispatch; lane 1 carries a foreign uop type
        lane(0, 6'd5, 1'b1, 6'd7, 1'b1, 6'd3);
        lane(1, 6'd8, 1'b1, 6'd8, 1'b1, 6'd4);
        disp_type[5:3] = 3'd1;
        exp_iss(6'd5, 6'd7, 6'd3);
        step();
        clr();
        chk("basic_count1", 64'(count), 64'd1);
        chk("basic_not_yet", 64'(iss_valid), 64'd0);
        step();
        chk("basic_iss_valid", 64'(iss_valid), 64'd1);
        chk("basic_count0", 64'(count), 64'd0);
        step();
        chk("basic_drain", 64'(iss_valid), 64'd0);

        // wakeup: non-regwr broadcast ignored, regwr broadcast wakes next cycle
        lane(0, 6'd1, 1'b1, 6'd9, 1'b0, 6'd10);
        step();
        clr();
        chk("wake_count", 64'(count), 64'd1);
        cdb(2, 1'b0, 6'd9);
        step();
        clr();
        step();
        chk("wake_noregwr", 64'(iss_valid), 64'd0);
        cdb(2, 1'b1, 6'd9);
        exp_iss(6'd1, 6'd9, 6'd10);
        step();
        clr();
        chk("wake_not_same_cycle", 64'(iss_valid), 64'd0);
        step();
        chk("wake_iss_valid", 64'(iss_valid), 64'd1);
        step();
        chk("wake_drain", 64'(count), 64'd0);

        // broadcast in the dispatch cycle captured into the new entry
        lane(0, 6'd2, 1'b1, 6'd9, 1'b0, 6'd11);
        cdb(0, 1'b1, 6'd9);
        exp_iss(6'd2, 6'd9, 6'd11);
        step();
        clr();
        chk("disp_wake_count", 64'(count), 64'd1);
        step();
        chk("disp_wake_iss", 64'(iss_valid), 64'd1);
        step();

        // age wraps around the ROB tag space
        ptr_old = 6'd62;
        lane(0, 6'd3, 1'b1, 6'd4, 1'b1, 6'd1);
        lane(1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd63);
        exp_iss(6'd3, 6'd4, 6'd63);
        exp_iss(6'd3, 6'd4, 6'd1);
        step();
        clr();
        step();
        step();
        step();
        chk("age_count", 64'(count), 64'd0);
        chk("age_drain", 64'(iss_valid), 64'd0);
        ptr_old = 6'd0;

        // backpressure holds the issue register and the queue
        iss_ready = 1'b0;
        for (int l = 0; l < 3; l++) begin
            lane(l, 6'(l), 1'b1, 6'd2, 1'b1, 6'(20 + l));
            exp_iss(6'(l), 6'd2, 6'(20 + l));
        end
        step();
        clr();
        chk("bp_count3", 64'(count), 64'd3);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_valid", 64'(iss_valid), 64'd1);
            chk("bp_hold_rob", 64'(iss_rob), 64'd20);
            chk("bp_hold_count", 64'(count), 64'd2);
        end
        iss_ready = 1'b1;
        step();
        chk("bp_count1", 64'(count), 64'd1);
        step();
        chk("bp_count0", 64'(count), 64'd0);
        step();
        chk("bp_drain", 64'(iss_valid), 64'd0);

        // fill to 14 non-ready entries, full blocks dispatch, one issue clears full
        for (int r = 0; r < 5; r++) begin
            for (int l = 0; l < ((r < 4) ? 3 : 2); l++)
                lane(l, 6'd1, 1'b1, 6'(30 + 3*r + l), 1'b0, 6'(30 + 3*r + l));
            step();
            clr();
        end
        chk("full_count", 64'(count), 64'd14);
        chk("full_set", 64'(full), 64'd1);
        lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50);
        step();
        clr();
        chk("full_ignored", 64'(count), 64'd14);
        step();
        chk("full_no_issue", 64'(iss_valid), 64'd0);
        cdb(1, 1'b1, 6'd35);
        exp_iss(6'd1, 6'd35, 6'd35);
        step();
        clr();
        chk("full_still", 64'(full), 64'd1);
        step();
        chk("full_count13", 64'(count), 64'd13);
        chk("full_clear", 64'(full), 64'd0);

        // flush with a held issue and same-cycle dispatch
        cdb(1, 1'b1, 6'd36);
        exp_iss(6'd1, 6'd36, 6'd36);
        step();
        clr();
        step();
        chk("fl_pre_valid", 64'(iss_valid), 64'd1);
        iss_ready = 1'b0;
        flush = 1'b1;
        lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd60);
        step();
        flush = 1'b0;
        clr();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_iss_valid", 64'(iss_valid), 64'd0);
        iss_ready = 1'b1;
        step();
        step();
        chk("fl_dropped", 64'(iss_valid), 64'd0);
        chk("fl_count_after", 64'(count), 64'd0);

        // asynchronous reset in mid-operation
        lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
        step();
        clr();
        chk("mr_count1", 64'(count), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_async_count", 64'(count), 64'd0);
        chk("mr_async_valid", 64'(iss_valid), 64'd0);
        #1 rst = 1'b1;
        step();
        chk("mr_no_issue", 64'(iss_valid), 64'd0);
        step();
        chk("mr_no_issue2", 64'(iss_valid), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
